mpu_sample_ctrl: RTL and testbench
==================================

Name: mpu_sample_ctrl

Overview:
Sequencer and frame assembler that sits directly above the MPU I2C top block. After reset it issues the one-time sensor init, then triggers a burst read at a fixed sample rate. It collects the 14-byte big-endian burst (accel XYZ, temperature, gyro XYZ) into seven signed 16-bit words and publishes them with a one-cycle valid strobe to the attitude/PID stage. It also detects bus stalls (timeout) and missed sample ticks (overrun).

Parameters:
CLK_HZ, 50_000_000, system clock frequency in Hz
SAMPLE_HZ, 200, read trigger rate; tick period = CLK_HZ/SAMPLE_HZ cycles
TIMEOUT_CYC, 1_000_000, maximum cycles allowed per init or per burst before abort
CAL_LOG2, 6, log2 of the number of frames averaged for gyro bias (optional feature only)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
init_start  out  1  one-cycle pulse requesting sensor init
init_done  in  1  init complete; any high cycle is accepted
read_start  out  1  one-cycle pulse requesting a 14-byte burst
byte_valid  in  1  received-byte strobe from the I2C path
byte_data  in  8  received byte, valid with byte_valid
accel_x, accel_y, accel_z  out  16 each  signed accelerometer samples
temp_raw  out  16  signed temperature sample
gyro_x, gyro_y, gyro_z  out  16 each  signed gyro samples (bias-corrected if feature on)
sample_valid  out  1  one-cycle strobe; all seven words are stable from this cycle until the next strobe
frame_cnt  out  16  count of published frames, wraps 0xFFFF->0
timeout_cnt  out  8  aborted operations, saturates at 255
overrun  out  1  sticky; set when a tick arrives while not in WAIT_TICK
cal_done  out  1  gyro bias valid; tied 1 when feature compiled out

Behaviour:
- Reset: synchronous, active-low, one clk. Every output returns to 0 (cal_done to 1 without the feature). The FSM enters RESET_WAIT, and all counters and any partial frame are cleared. Reset mid-burst discards the partial frame.
- FSM states:
  - RESET_WAIT: runs 16 cycles, then moves to INIT.
  - INIT: pulses init_start in the first cycle, then waits for init_done. On init_done: tick counter is cleared and the FSM moves to WAIT_TICK. After TIMEOUT_CYC cycles without init_done: timeout_cnt increments and INIT repeats (init_start pulses again).
  - WAIT_TICK: on tick, pulses read_start, clears byte index and timeout counter, and moves to READ.
  - READ: each byte_valid stores byte_data at index idx (0..13) and increments idx. Even index loads the high byte, odd index the low byte. Word order is ax, ay, az, t, gx, gy, gz. When the byte at idx 13 is stored, the FSM moves to PUBLISH. The timeout counter restarts on every byte_valid. After TIMEOUT_CYC idle cycles: timeout_cnt increments, the frame is dropped, and the FSM returns to WAIT_TICK.
  - PUBLISH: for one cycle, copies the shadow words to the outputs, asserts sample_valid, increments frame_cnt, then moves to WAIT_TICK. Latency: sample_valid rises exactly 2 cycles after the clk edge that captured byte 13.
- Tick: free-running period counter, started when INIT exits. A tick while in READ or PUBLISH sets overrun and is dropped; no queued read.
- byte_valid outside READ is ignored.
- Output words are registered. Shadow registers are used during READ, so outputs never show a mixed frame.

Optional Feature:
Macro MPU_GYRO_CAL_EN.
- Defined:
  - Frames 0..2^CAL_LOG2-1 after init are accumulated per gyro axis into sign-extended (16+CAL_LOG2)-bit sums. sample_valid is suppressed for these frames and frame_cnt does not advance.
  - Then bias = sum >>> CAL_LOG2 (arithmetic shift) and cal_done rises.
  - Published gyro = raw − bias, saturated to [−32768, 32767].
  - A re-init after reset recalibrates.
- Undefined: gyro passes raw, cal_done = 1, no accumulators are synthesised.

Decomposition:
- Shared package mpu_pkg: FSM state encoding, BYTES_PER_FRAME = 14, word index constants (IDX_AX..IDX_GZ), sample word width 16.
- One sub-module, mpu_gyro_bias: per-axis accumulate, shift and saturating subtract. Instantiated only under MPU_GYRO_CAL_EN.

Test Plan:
- Reset, then init_done at cycle 40 → exactly one init_start pulse; first read_start exactly CLK_HZ/SAMPLE_HZ cycles after init_done.
- Bytes 0x12,0x34,0xFF,0xFE,…,0x80,0x00 → accel_x = 0x1234, accel_y = −2, gyro_z = −32768; sample_valid 2 cycles after last byte; frame_cnt = 1.
- Stop after 9 bytes with TIMEOUT_CYC = 100 → timeout_cnt = 1, no sample_valid, outputs unchanged; next tick's full burst publishes correctly.
- SAMPLE_HZ such that period is shorter than the burst → overrun = 1, read_start count equals completed frames + 1, no dropped bytes.
- Assert rst_n low at byte 7 → all outputs 0; after re-init, a full frame publishes with frame_cnt = 1.
- MPU_GYRO_CAL_EN, CAL_LOG2 = 2: four frames with gyro_x = 100, then raw 150 → no valid for the first 4, cal_done = 1, gyro_x = 50; raw −32700 with bias 100 → −32768.

Source files
------------

// File: rtl/mpu_pkg.sv
// Shared definitions for the MPU sample sequencer: FSM encoding, frame geometry
// and word slot indices.
package mpu_pkg;

  typedef enum logic [2:0] {
    S_RESET_WAIT,
    S_INIT,
    S_WAIT_TICK,
    S_READ,
    S_PUBLISH
  } state_t;

  localparam int unsigned WORD_W          = 16;
  localparam int unsigned BYTES_PER_FRAME = 14;
  localparam int unsigned NUM_WORDS       = BYTES_PER_FRAME / 2;
  localparam int unsigned RESET_WAIT_CYC  = 16;

  localparam int unsigned IDX_AX = 0;
  localparam int unsigned IDX_AY = 1;
  localparam int unsigned IDX_AZ = 2;
  localparam int unsigned IDX_T  = 3;
  localparam int unsigned IDX_GX = 4;
  localparam int unsigned IDX_GY = 5;
  localparam int unsigned IDX_GZ = 6;

endpackage

// File: rtl/mpu_gyro_bias.sv
// One gyro axis: accumulates calibration frames, derives bias = sum >>> CAL_LOG2
// and presents the saturated bias-corrected sample. Used under MPU_GYRO_CAL_EN.
module mpu_gyro_bias
  import mpu_pkg::*;
#(
  parameter int unsigned CAL_LOG2 = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              acc,
  input  logic [WORD_W-1:0] raw,
  output logic [WORD_W-1:0] corr
);

  logic [WORD_W+CAL_LOG2-1:0] sum;
  logic [WORD_W-1:0]          bias;
  logic [WORD_W:0]            diff;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum <= '0;
    end else if (acc) begin
      sum <= sum + {{CAL_LOG2{raw[WORD_W-1]}}, raw};
    end
  end

  // Arithmetic shift of a sign-extended sum: the low WORD_W bits above the
  // discarded fraction are exactly the bias.
  assign bias = sum[CAL_LOG2 +: WORD_W];
  assign diff = {raw[WORD_W-1], raw} - {bias[WORD_W-1], bias};

  always_comb begin
    corr = diff[WORD_W-1:0];
    if (diff[WORD_W] != diff[WORD_W-1]) begin
      corr = diff[WORD_W] ? {1'b1, {(WORD_W-1){1'b0}}} : {1'b0, {(WORD_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/mpu_sample_ctrl.sv
// Init/sample sequencer and 14-byte frame assembler above the MPU I2C block.
// Optional gyro bias calibration is enabled with the MPU_GYRO_CAL_EN macro.
module mpu_sample_ctrl
  import mpu_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned SAMPLE_HZ   = 200,
  parameter int unsigned TIMEOUT_CYC = 1_000_000,
  parameter int unsigned CAL_LOG2    = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        init_start,
  input  logic        init_done,
  output logic        read_start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [15:0] accel_x,
  output logic [15:0] accel_y,
  output logic [15:0] accel_z,
  output logic [15:0] temp_raw,
  output logic [15:0] gyro_x,
  output logic [15:0] gyro_y,
  output logic [15:0] gyro_z,
  output logic        sample_valid,
  output logic [15:0] frame_cnt,
  output logic [7:0]  timeout_cnt,
  output logic        overrun,
  output logic        cal_done
);

  localparam int unsigned PERIOD = CLK_HZ / SAMPLE_HZ;
  localparam int unsigned TW     = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned PW     = $clog2(PERIOD + 1);

  state_t            state, nstate;
  logic [3:0]        rw_cnt;
  logic [TW-1:0]     tcnt;
  logic [PW-1:0]     tick_cnt;
  logic              tick_run, tick, to_hit, to_event, tcnt_clr;
  logic              bv_q;
  logic [7:0]        bd_q;
  logic [3:0]        idx;
  logic [WORD_W-1:0] shadow [NUM_WORDS];
  logic [WORD_W-1:0] gx_pub, gy_pub, gz_pub;
  logic              publish_en;

  assign tick   = tick_run && (tick_cnt == PW'(PERIOD - 1));
  assign to_hit = (tcnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_RESET_WAIT;
    else        state <= nstate;
  end

  always_comb begin
    nstate     = state;
    init_start = 1'b0;
    read_start = 1'b0;
    unique case (state)
      S_RESET_WAIT: if (rw_cnt == 4'(RESET_WAIT_CYC - 1)) nstate = S_INIT;
      S_INIT: begin
        init_start = (tcnt == '0);
        if (init_done) nstate = S_WAIT_TICK;
      end
      S_WAIT_TICK: if (tick) begin
        read_start = 1'b1;
        nstate     = S_READ;
      end
      S_READ: begin
        if (bv_q && idx == 4'(BYTES_PER_FRAME - 1)) nstate = S_PUBLISH;
        else if (!bv_q && to_hit)                   nstate = S_WAIT_TICK;
      end
      S_PUBLISH: nstate = S_WAIT_TICK;
      default:   nstate = S_RESET_WAIT;
    endcase
  end

  // A timed-out INIT clears tcnt and stays, so init_start re-fires next cycle.
  assign to_event = to_hit && ((state == S_INIT && !init_done) || (state == S_READ && !bv_q));
  assign tcnt_clr = !(state == S_INIT || state == S_READ) || to_hit ||
                    (state == S_INIT && init_done) || (state == S_READ && bv_q);

`ifdef MPU_GYRO_CAL_EN
  logic                cal_acc, cal_ok;
  logic [CAL_LOG2-1:0] cal_cnt;

  assign cal_acc    = (state == S_PUBLISH) && !cal_ok;
  assign publish_en = (state == S_PUBLISH) && cal_ok;
  assign cal_done   = cal_ok;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cal_cnt <= '0;
      cal_ok  <= 1'b0;
    end else if (cal_acc) begin
      cal_cnt <= cal_cnt + 1'b1;
      if (&cal_cnt) cal_ok <= 1'b1;
    end
  end

  mpu_gyro_bias #(.CAL_LOG2(CAL_LOG2)) u_bias_x (
    .clk(clk), .rst_n(rst_n), .acc(cal_acc), .raw(shadow[IDX_GX]), .corr(gx_pub));
  mpu_gyro_bias #(.CAL_LOG2(CAL_LOG2)) u_bias_y (
    .clk(clk), .rst_n(rst_n), .acc(cal_acc), .raw(shadow[IDX_GY]), .corr(gy_pub));
  mpu_gyro_bias #(.CAL_LOG2(CAL_LOG2)) u_bias_z (
    .clk(clk), .rst_n(rst_n), .acc(cal_acc), .raw(shadow[IDX_GZ]), .corr(gz_pub));
`else
  assign publish_en = (state == S_PUBLISH);
  assign gx_pub     = shadow[IDX_GX];
  assign gy_pub     = shadow[IDX_GY];
  assign gz_pub     = shadow[IDX_GZ];
  // No calibration path: bias is always considered valid.
  assign cal_done   = (CAL_LOG2 < 32);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rw_cnt       <= '0;
      tcnt         <= '0;
      tick_cnt     <= '0;
      tick_run     <= 1'b0;
      bv_q         <= 1'b0;
      bd_q         <= '0;
      idx          <= '0;
      for (int unsigned i = 0; i < NUM_WORDS; i++) shadow[i] <= '0;
      accel_x      <= '0;
      accel_y      <= '0;
      accel_z      <= '0;
      temp_raw     <= '0;
      gyro_x       <= '0;
      gyro_y       <= '0;
      gyro_z       <= '0;
      sample_valid <= 1'b0;
      frame_cnt    <= '0;
      timeout_cnt  <= '0;
      overrun      <= 1'b0;
    end else begin
      if (state == S_RESET_WAIT) rw_cnt <= rw_cnt + 1'b1;
      tcnt <= tcnt_clr ? '0 : tcnt + 1'b1;
      if (to_event && timeout_cnt != 8'hFF) timeout_cnt <= timeout_cnt + 1'b1;

      if (state == S_INIT && init_done) begin
        tick_run <= 1'b1;
        tick_cnt <= '0;
      end else if (tick_run) begin
        tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      end
      if (tick && state != S_WAIT_TICK) overrun <= 1'b1;

      // Bytes are registered once before assembly; anything outside READ is dropped here.
      bv_q <= byte_valid && (state == S_READ);
      bd_q <= byte_data;
      if (state == S_WAIT_TICK) idx <= '0;
      else if (state == S_READ && bv_q) begin
        idx <= idx + 1'b1;
        if (idx[0]) shadow[idx[3:1]][7:0]  <= bd_q;
        else        shadow[idx[3:1]][15:8] <= bd_q;
      end

      sample_valid <= publish_en;
      if (publish_en) begin
        accel_x   <= shadow[IDX_AX];
        accel_y   <= shadow[IDX_AY];
        accel_z   <= shadow[IDX_AZ];
        temp_raw  <= shadow[IDX_T];
        gyro_x    <= gx_pub;
        gyro_y    <= gy_pub;
        gyro_z    <= gz_pub;
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mpu_sample_ctrl.sv
// Directed bench for mpu_sample_ctrl: init sequencing, frame assembly, latency,
// timeout, overrun, mid-burst reset and (with MPU_GYRO_CAL_EN) gyro calibration.
module tb_mpu_sample_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init_done = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = '0;
  logic        init_start, read_start, sample_valid, overrun, cal_done;
  logic [15:0] accel_x, accel_y, accel_z, temp_raw, gyro_x, gyro_y, gyro_z, frame_cnt;
  logic [7:0]  timeout_cnt;
  logic [111:0] w;

  int checks = 0, passed = 0;
  int cyc = 0, is_cnt = 0, rs_cnt = 0, sv_cnt = 0, done_cyc = 0, rs_cyc = 0;

  localparam logic [111:0] F1 = 112'h1234_FFFE_7FFF_0000_0001_ABCD_8000;
  localparam logic [111:0] F2 = 112'hA1A2_B1B2_C1C2_D1D2_E1E2_F1F2_0102;
  localparam logic [111:0] F3 = 112'h0011_2233_4455_6677_8899_AABB_CCDD;
  localparam logic [111:0] F4 = 112'h5A5A_A5A5_0F0F_F0F0_1357_2468_7F80;

  always #5 clk = ~clk;

  mpu_sample_ctrl #(
    .CLK_HZ(50_000), .SAMPLE_HZ(100), .TIMEOUT_CYC(100), .CAL_LOG2(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .init_start(init_start), .init_done(init_done),
    .read_start(read_start), .byte_valid(byte_valid), .byte_data(byte_data),
    .accel_x(accel_x), .accel_y(accel_y), .accel_z(accel_z), .temp_raw(temp_raw),
    .gyro_x(gyro_x), .gyro_y(gyro_y), .gyro_z(gyro_z), .sample_valid(sample_valid),
    .frame_cnt(frame_cnt), .timeout_cnt(timeout_cnt), .overrun(overrun), .cal_done(cal_done)
  );

  assign w = {accel_x, accel_y, accel_z, temp_raw, gyro_x, gyro_y, gyro_z};

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (init_start)   is_cnt <= is_cnt + 1;
    if (read_start)   begin rs_cnt <= rs_cnt + 1; rs_cyc <= cyc; end
    if (sample_valid) sv_cnt <= sv_cnt + 1;
    if (init_done)    done_cyc <= cyc;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_init();
    repeat (39) step();
    init_done = 1'b1;
    step();
    init_done = 1'b0;
  endtask

  task automatic wait_read(input string tag);
    int start;
    start = rs_cnt;
    for (int i = 0; i < 1200 && rs_cnt == start; i++) step();
    checks++;
    if (rs_cnt == start) $display("FAIL %s: read_start got none, expected one within 1200 cycles", tag);
    else passed++;
  endtask

  task automatic send_bytes(input logic [111:0] f, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      byte_valid = 1'b1;
      byte_data  = f[111-8*i -: 8];
      step();
      byte_valid = 1'b0;
      repeat (gap) step();
    end
  endtask

  task automatic test_reset();
    logic exp_cal;
`ifdef MPU_GYRO_CAL_EN
    exp_cal = 1'b0;
`else
    exp_cal = 1'b1;
`endif
    rst_n = 1'b0;
    repeat (3) step();
    checks++; if (w !== '0) $display("FAIL reset_words: got %h expected 0", w); else passed++;
    checks++; if ({sample_valid, overrun, init_start, read_start} !== 4'b0)
      $display("FAIL reset_flags: got %b expected 0000", {sample_valid, overrun, init_start, read_start}); else passed++;
    checks++; if (frame_cnt !== 16'd0) $display("FAIL reset_frame_cnt: got %0d expected 0", frame_cnt); else passed++;
    checks++; if (timeout_cnt !== 8'd0) $display("FAIL reset_timeout_cnt: got %0d expected 0", timeout_cnt); else passed++;
    checks++; if (cal_done !== exp_cal) $display("FAIL reset_cal_done: got %b expected %b", cal_done, exp_cal); else passed++;
  endtask

  task automatic test_init();
    rst_n = 1'b1;
    do_init();
    wait_read("init_first_read");
    checks++; if (is_cnt !== 1) $display("FAIL init_pulses: got %0d expected 1", is_cnt); else passed++;
    checks++; if (rs_cyc - done_cyc !== 500)
      $display("FAIL init_to_read: got %0d cycles expected 500", rs_cyc - done_cyc); else passed++;
  endtask

  task automatic test_frame();
    send_bytes(F1, 14, 0);
    step();
    checks++; if (sample_valid !== 1'b0) $display("FAIL latency_early: got %b expected 0", sample_valid); else passed++;
    step();
    checks++; if (sample_valid !== 1'b1) $display("FAIL latency: got %b expected 1", sample_valid); else passed++;
    checks++; if (w !== F1) $display("FAIL frame1_words: got %h expected %h", w, F1); else passed++;
    checks++; if (accel_x !== 16'h1234) $display("FAIL accel_x: got %h expected 1234", accel_x); else passed++;
    checks++; if (accel_y !== 16'hFFFE) $display("FAIL accel_y: got %h expected fffe", accel_y); else passed++;
    checks++; if (gyro_z !== 16'h8000) $display("FAIL gyro_z: got %h expected 8000", gyro_z); else passed++;
    checks++; if (frame_cnt !== 16'd1) $display("FAIL frame1_cnt: got %0d expected 1", frame_cnt); else passed++;
    step();
    checks++; if (sample_valid !== 1'b0) $display("FAIL valid_width: got %b expected 0", sample_valid); else passed++;
  endtask

  task automatic test_timeout();
    int sv0;
    sv0 = sv_cnt;
    wait_read("timeout_read");
    send_bytes(F2, 9, 0);
    repeat (150) step();
    checks++; if (timeout_cnt !== 8'd1) $display("FAIL timeout_cnt: got %0d expected 1", timeout_cnt); else passed++;
    checks++; if (sv_cnt !== sv0) $display("FAIL timeout_no_valid: got %0d strobes expected %0d", sv_cnt, sv0); else passed++;
    checks++; if (w !== F1) $display("FAIL timeout_hold: got %h expected %h", w, F1); else passed++;
    byte_valid = 1'b1; byte_data = 8'hEE;
    step();
    byte_valid = 1'b0;
    wait_read("after_timeout_read");
    send_bytes(F2, 14, 0);
    repeat (3) step();
    checks++; if (w !== F2) $display("FAIL frame2_words: got %h expected %h", w, F2); else passed++;
    checks++; if (frame_cnt !== 16'd2) $display("FAIL frame2_cnt: got %0d expected 2", frame_cnt); else passed++;
    checks++; if (overrun !== 1'b0) $display("FAIL overrun_clear: got %b expected 0", overrun); else passed++;
  endtask

  task automatic test_overrun();
    wait_read("overrun_read");
    send_bytes(F3, 14, 39);
    repeat (3) step();
    checks++; if (overrun !== 1'b1) $display("FAIL overrun: got %b expected 1", overrun); else passed++;
    checks++; if (w !== F3) $display("FAIL frame3_words: got %h expected %h", w, F3); else passed++;
    checks++; if (frame_cnt !== 16'd3) $display("FAIL frame3_cnt: got %0d expected 3", frame_cnt); else passed++;
    checks++; if (rs_cnt !== 4) $display("FAIL read_count: got %0d expected 4", rs_cnt); else passed++;
    checks++; if (timeout_cnt !== 8'd1) $display("FAIL overrun_timeouts: got %0d expected 1", timeout_cnt); else passed++;
  endtask

  task automatic test_mid_reset();
    int is0;
    wait_read("midreset_read");
    send_bytes(F4, 7, 0);
    rst_n = 1'b0;
    repeat (2) step();
    checks++; if (w !== '0) $display("FAIL midreset_words: got %h expected 0", w); else passed++;
    checks++; if ({frame_cnt, timeout_cnt, overrun, sample_valid} !== 26'd0)
      $display("FAIL midreset_status: got %h expected 0", {frame_cnt, timeout_cnt, overrun, sample_valid}); else passed++;
    is0 = is_cnt;
    rst_n = 1'b1;
    do_init();
    wait_read("reinit_read");
    checks++; if (is_cnt !== is0 + 1) $display("FAIL reinit_pulses: got %0d expected %0d", is_cnt, is0 + 1); else passed++;
    send_bytes(F4, 14, 0);
    repeat (3) step();
    checks++; if (w !== F4) $display("FAIL frame4_words: got %h expected %h", w, F4); else passed++;
    checks++; if (frame_cnt !== 16'd1) $display("FAIL frame4_cnt: got %0d expected 1", frame_cnt); else passed++;
  endtask

`ifdef MPU_GYRO_CAL_EN
  task automatic test_gyro_cal();
    int sv0;
    sv0 = sv_cnt;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) wait_read("cal_read");
      send_bytes(112'h0000_0000_0000_0000_0064_0000_0000, 14, 0);
      repeat (3) step();
    end
    checks++; if (sv_cnt !== sv0) $display("FAIL cal_no_valid: got %0d strobes expected %0d", sv_cnt, sv0); else passed++;
    checks++; if (frame_cnt !== 16'd0) $display("FAIL cal_frame_cnt: got %0d expected 0", frame_cnt); else passed++;
    checks++; if (cal_done !== 1'b1) $display("FAIL cal_done: got %b expected 1", cal_done); else passed++;
    wait_read("cal_pub_read");
    send_bytes(112'h0000_0000_0000_0000_0096_0000_0000, 14, 0);
    repeat (3) step();
    checks++; if (sv_cnt !== sv0 + 1) $display("FAIL cal_valid: got %0d strobes expected %0d", sv_cnt, sv0 + 1); else passed++;
    checks++; if (gyro_x !== 16'h0032) $display("FAIL cal_gyro_x: got %h expected 0032", gyro_x); else passed++;
    wait_read("cal_sat_read");
    send_bytes(112'h0000_0000_0000_0000_8044_0000_0000, 14, 0);
    repeat (3) step();
    checks++; if (gyro_x !== 16'h8000) $display("FAIL cal_saturate: got %h expected 8000", gyro_x); else passed++;
    checks++; if (frame_cnt !== 16'd2) $display("FAIL cal_frame_cnt2: got %0d expected 2", frame_cnt); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_init();
`ifdef MPU_GYRO_CAL_EN
    test_gyro_cal();
`else
    test_frame();
    test_timeout();
    test_overrun();
    test_mid_reset();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
